// File: rtl/param_pkg.sv
// Shared AHB fabric constants: bus encodings, arbiter state type, burst length helper.
package param_pkg;

   localparam int NUM_MASTERS = 4;
   localparam int BEAT_W      = 5;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   typedef enum logic [1:0] {
      ST_PARK   = 2'd0,
      ST_OWNED  = 2'd1,
      ST_LOCKED = 2'd2
   } arb_state_e;

   // Beats remaining after the NONSEQ beat; undefined-length INCR reports 0.
   function automatic logic [BEAT_W-1:0] burst_beats_m1(input logic [2:0] burst);
      logic [BEAT_W-1:0] r;
      r = '0;
      case (burst)
         HBURST_WRAP4,  HBURST_INCR4:  r = 5'd3;
         HBURST_WRAP8,  HBURST_INCR8:  r = 5'd7;
         HBURST_WRAP16, HBURST_INCR16: r = 5'd15;
         default:                      r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: the master after 'last' has top priority,
// 'last' itself has the lowest.
module ahb_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant,
   output logic             valid
);

   int d;
   int best_d;
   int best_i;

   // Pick the requester with the smallest rotated distance from last+1.
   always_comb begin
      d      = 0;
      best_d = N;
      best_i = 0;
      grant  = '0;
      for (int i = 0; i < N; i++) begin
         d = (i - int'(last) - 1 + 2 * N) % N;
         if (req[i] && (d < best_d)) begin
            best_d = d;
            best_i = i;
         end
      end
      valid = (best_d < N);
      for (int i = 0; i < N; i++) begin
         grant[i] = valid && (i == best_i);
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with bus parking, burst-aware handover and locking.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_PARK   | default master granted, nobody requesting
// ST_OWNED  | a requesting master holds the grant
// ST_LOCKED | owner holds HLOCK, grant frozen until it drops
module ahb_arbiter #(
   parameter int NUM_MASTERS    = param_pkg::NUM_MASTERS,
   parameter int DEFAULT_MASTER = 0,
   parameter int MIDX_W         = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MIDX_W-1:0]      HMASTER,
   output logic [MIDX_W-1:0]      HMASTER_DATA,
   output logic                   HMASTLOCK
);

   import param_pkg::*;

   localparam logic [MIDX_W-1:0] DEF_IDX = MIDX_W'(DEFAULT_MASTER);

   arb_state_e              state;
   arb_state_e              state_next;
   logic [MIDX_W-1:0]       last_granted;
   logic [MIDX_W-1:0]       idx_next;
   logic [NUM_MASTERS-1:0]  grant_next;
   logic [BEAT_W-1:0]       beats_left;
   logic [BEAT_W-1:0]       beats_next;
   logic [NUM_MASTERS-1:0]  pick_grant;
   logic                    pick_valid;
   logic [MIDX_W-1:0]       pick_idx;
   logic                    own_lock;
   logic                    own_req;
   logic                    burst_end;
   logic                    arb_cond;

   ahb_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (MIDX_W)
   ) u_picker (
      .req   (HBUSREQ),
      .last  (last_granted),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // Beat tracking and arbitration-point detection for the current address phase.
   always_comb begin
      beats_next = beats_left;
      case (HTRANS)
         HTRANS_NONSEQ: beats_next = burst_beats_m1(HBURST);
         HTRANS_SEQ:    beats_next = (beats_left == '0) ? '0 : beats_left - 5'd1;
         HTRANS_IDLE:   beats_next = '0;
         default:       beats_next = beats_left;
      endcase
      own_lock  = HLOCK[last_granted];
      own_req   = HBUSREQ[last_granted];
      burst_end = (HBURST != HBURST_INCR) &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                  (beats_next <= 5'd1);
      arb_cond  = (HTRANS == HTRANS_IDLE) || !own_req || burst_end;
      pick_idx  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_grant[i]) pick_idx = MIDX_W'(i);
      end
   end

   // Next-state and next-owner decision; a held lock always wins over arbitration.
   always_comb begin
      state_next = state;
      idx_next   = last_granted;
      if (own_lock) begin
         state_next = ST_LOCKED;
      end else if ((state == ST_LOCKED) || arb_cond) begin
         if (pick_valid) begin
            idx_next   = pick_idx;
            state_next = ST_OWNED;
         end else begin
            idx_next   = DEF_IDX;
            state_next = ST_PARK;
         end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         grant_next[i] = (idx_next == MIDX_W'(i));
      end
   end

   // State register; everything freezes while HREADY is low.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_PARK;
      end else if (HREADY) begin
         state <= state_next;
      end
   end

   // Grant, ownership pipeline and beat counter.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_granted <= DEF_IDX;
         HGRANT       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
         HMASTER      <= DEF_IDX;
         HMASTER_DATA <= DEF_IDX;
         HMASTLOCK    <= 1'b0;
         beats_left   <= '0;
      end else if (HREADY) begin
         last_granted <= idx_next;
         HGRANT       <= grant_next;
         HMASTER      <= last_granted;
         HMASTER_DATA <= HMASTER;
         HMASTLOCK    <= own_lock;
         beats_left   <= beats_next;
      end
   end

endmodule
